soc_uart_tx: RTL and testbench
==============================

# soc_uart_tx

Bus-attached UART transmitter peripheral for the SoC memory map, sitting directly downstream of the CPU bus multiplexer's chip-select decode next to ROM, RAM and the GPIO pin.
- The CPU writes bytes into a FIFO.
- A baud-rate FSM serialises them onto a single TX line as 8N1 frames.
- A status register lets firmware poll for space or completion without stalling.

## Interface
- FREQUENCY, 25000000, system clock frequency in Hz.
- BAUDRATE, 115200, line rate. Divider DIV = FREQUENCY / BAUDRATE, integer-truncated (217 at defaults).
- FIFO_DEPTH, 16, TX FIFO entries. Must be a power of two and ≥ 2.
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  bus access request; the SoC already qualifies it with this block's chip select.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  byte address; only [3:2] decoded.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, registered, valid while o_ready = 1.
- o_ready  out  1  one-cycle access completion pulse.
- o_tx  out  1  serial line, idle high.
- o_interrupt  out  1  level interrupt (see Configuration).

## Operation
- Register map, selected by i_address[3:2]:
  - 0: DATA. A write pushes i_wdata[7:0] into the FIFO. A read returns 0.
  - 1: STATUS, read-only. bit0 = FIFO full, bit1 = FIFO empty, bit2 = transmitter busy (FSM not IDLE), other bits 0. Writes are acknowledged and ignored.
  - 2: CTRL. bit0 = interrupt enable. Present only with the macro; otherwise reads 0 and writes are ignored.
  - 3: reads 0; writes are ignored.
- Handshake:
  - A request is sampled on an edge where i_request = 1 and o_ready = 0.
  - o_ready is high for exactly one cycle.
  - A request still high during the o_ready cycle is not a new access. Back-to-back accesses therefore complete at best every 2 cycles.
- A DATA write while the FIFO is full stalls: o_ready is withheld until an entry frees. The push and o_ready happen on the same edge.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH) that wrap naturally; count width is $clog2(FIFO_DEPTH)+1.
  - A simultaneous push and pop updates both pointers and leaves the count unchanged.
- TX FSM, with a baud counter counting 0..DIV-1 and each state lasting exactly DIV cycles:
  - IDLE: o_tx = 1. If the FIFO is non-empty, pop a byte into the shift register and go to START.
  - START: o_tx = 0, then go to DATA.
  - DATA: 8 bits, LSB first, bit index 0..7, then go to STOP.
  - STOP: o_tx = 1. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- A frame is 10·DIV cycles.

## Timing
- Reset values:
  - o_tx = 1, o_ready = 0, o_rdata = 0, o_interrupt = 0.
  - FIFO empty, FSM IDLE, CTRL = 0.
- Reset asserted mid-frame: on the next edge o_tx = 1 and the frame is aborted. FIFO contents and any pending stalled write are discarded.
- Read latency: request sampled at edge N → o_ready and o_rdata valid after edge N+1.
- Write to an empty FIFO with the FSM IDLE:
  - push at edge N+1 (o_ready high);
  - pop at edge N+2, where o_tx falls;
  - o_tx rises after edge N+2+9·DIV for the stop bit.
- STATUS reflects the state registered at the sampling edge.

## Configuration
- UART_TX_IRQ_EN defined:
  - CTRL register is implemented.
  - o_interrupt = CTRL.bit0 & FIFO empty & FSM IDLE, registered with one-cycle latency.
- Not defined:
  - o_interrupt tied 0.
  - CTRL reads 0 and writes are ignored.
  - No CTRL flop is synthesised.

## Test plan
- Test parameters: FREQUENCY = 1000, BAUDRATE = 100, so DIV = 10; FIFO_DEPTH = 4.
- Reset, then idle 50 cycles → o_tx = 1 throughout, o_ready = 0, STATUS read = 0x2.
- Write 0x55 to DATA → o_ready 1 cycle later; o_tx = 0,1,0,1,0,1,0,1,0,1 in 10-cycle slots: start 0, LSB first, stop 1. Total 100 cycles, then STATUS = 0x2.
- Write 6 bytes 0x01..0x06 back-to-back → writes 1–5 acknowledge promptly: the first is popped immediately, leaving a 4-entry FIFO. The 6th stalls until the first frame's stop completes. Frames are contiguous with no idle gap, and STATUS bit0 = 1 during the stall.
- Assert i_reset for 1 cycle during bit 3 of 0xA5 → o_tx = 1 on the next edge, STATUS = 0x2, no further frames.
- With UART_TX_IRQ_EN: write CTRL = 1, then DATA = 0xFF → o_interrupt drops while busy and reasserts 1 cycle after the FSM returns to IDLE. Without the macro, o_interrupt stays 0 and a CTRL read returns 0.

Source files
------------

// File: rtl/soc_uart_tx.sv
// Bus-attached 8N1 UART transmitter: CPU-written TX FIFO drained by a baud-rate serialiser.
// Define UART_TX_IRQ_EN to implement the CTRL register and the TX-done level interrupt.
module soc_uart_tx #(
  parameter int FREQUENCY  = 25000000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_interrupt
);

  localparam int DIV = FREQUENCY / BAUDRATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t        state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wPtr_q, rPtr_q;
  logic [PW:0]     count_q;

  logic            pend_q, pendRw_q;
  logic [1:0]      pendAddr_q;
  logic [7:0]      pendData_q;
  logic            ready_q;
  logic [31:0]     rdata_q, rdata_d;

  logic            fifoEmpty, fifoFull, baudEnd, pop, push;
  logic            accept, isDataWr, complete, busy;
  logic [31:0]     readValue, ctrlRead;

  wire unusedBits = &{1'b0, i_address[31:4], i_address[1:0], i_wdata[31:8]};

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign baudEnd   = (baud_q == CNT_LAST);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = mem[rPtr_q];
          state_d = START;
        end
      end
      START: begin
        if (baudEnd) begin
          baud_d   = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baudEnd) begin
          baud_d = '0;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            shift_d  = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap
        if (baudEnd) begin
          baud_d = '0;
          if (!fifoEmpty) begin
            pop     = 1'b1;
            shift_d = mem[rPtr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign accept   = i_request & ~ready_q & ~pend_q;
  assign isDataWr = pend_q & pendRw_q & (pendAddr_q == 2'd0);
  // A full FIFO may still accept a push on the edge the serialiser pops
  assign push     = isDataWr & (~fifoFull | pop);
  assign complete = pend_q & (~isDataWr | push);

  always_comb begin
    case (pendAddr_q)
      2'd1:    readValue = {29'b0, busy, fifoEmpty, fifoFull};
      2'd2:    readValue = ctrlRead;
      default: readValue = '0;
    endcase
    rdata_d = (complete && !pendRw_q) ? readValue : '0;
  end

  always_ff @(posedge i_clock) begin
    if (push) mem[wPtr_q] <= pendData_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wPtr_q     <= '0;
      rPtr_q     <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pendRw_q   <= 1'b0;
      pendAddr_q <= '0;
      pendData_q <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      if (push) wPtr_q <= wPtr_q + PW'(1);
      if (pop)  rPtr_q <= rPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (accept) begin
        pend_q     <= 1'b1;
        pendRw_q   <= i_rw;
        pendAddr_q <= i_address[3:2];
        pendData_q <= i_wdata[7:0];
      end else if (complete) begin
        pend_q <= 1'b0;
      end
      ready_q <= complete;
      rdata_q <= rdata_d;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic ctrl_q, irq_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ctrl_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (complete && pendRw_q && pendAddr_q == 2'd2) ctrl_q <= pendData_q[0];
      irq_q <= ctrl_q & fifoEmpty & (state_q == IDLE);
    end
  end

  assign ctrlRead    = {31'b0, ctrl_q};
  assign o_interrupt = irq_q;
`else
  assign ctrlRead    = '0;
  assign o_interrupt = 1'b0;
`endif

  assign o_rdata = rdata_q;
  assign o_ready = ready_q;
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_soc_uart_tx.sv
// Self-checking bench for soc_uart_tx: bus accesses plus a serial-line monitor
// that decodes every frame against a queue of bytes written to DATA.
module tb_soc_uart_tx;

  localparam int DIV = 10;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_tx;
  logic        o_interrupt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          readyCyc = 0;
  int          lastStartCyc = 0;
  int          framesSeen = 0;
  logic [7:0]  expQ [$];
  int          starts [$];

  soc_uart_tx #(
    .FREQUENCY (1000),
    .BAUDRATE  (100),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_request  (i_request),
    .i_rw       (i_rw),
    .i_address  (i_address),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ready    (o_ready),
    .o_tx       (o_tx),
    .o_interrupt(o_interrupt)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One bus access; DATA writes queue their byte for the line monitor
  task automatic applyStimulus(input logic rw, input logic [1:0] regSel, input logic [31:0] data,
                               output logic [31:0] rdata, output int lat);
    i_request = 1'b1;
    i_rw      = rw;
    i_address = {28'b0, regSel, 2'b00};
    i_wdata   = data;
    lat       = 0;
    if (rw && regSel == 2'd0) expQ.push_back(data[7:0]);
    do begin
      @(negedge i_clock);
      lat++;
    end while (!o_ready && lat < 2000);
    if (!o_ready) checkOutput("accessTimeout", 32'd0, 32'd1);
    rdata     = o_rdata;
    readyCyc  = cyc;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_wdata   = '0;
    @(negedge i_clock);
    checkOutput("readyPulse", {31'b0, o_ready}, 32'd0);
  endtask

  // Line monitor: sampled just after each rising edge, checks every cycle of each frame
  initial begin
    logic       prevTx = 1'b1;
    logic       inFrame = 1'b0;
    logic [9:0] pattern = '1;
    logic [7:0] expByte = '0;
    logic [7:0] data = '0;
    int         t = 0;
    int         slot;
    int         shapeErr = 0;
    forever begin
      @(posedge i_clock);
      #1;
      if (i_reset) begin
        inFrame = 1'b0;
        prevTx  = 1'b1;
      end else begin
        if (!inFrame && prevTx && !o_tx) begin
          inFrame  = 1'b1;
          t        = 0;
          shapeErr = 0;
          data     = '0;
          starts.push_back(cyc);
          lastStartCyc = cyc;
          if (expQ.size() == 0) begin
            checkOutput("unexpectedFrame", 32'd1, 32'd0);
            expByte = '0;
          end else begin
            expByte = expQ.pop_front();
          end
          pattern = {1'b1, expByte, 1'b0};
        end
        if (inFrame) begin
          slot = t / DIV;
          if (o_tx !== pattern[slot]) shapeErr++;
          if (slot >= 1 && slot <= 8 && (t % DIV) == DIV / 2) data[slot-1] = o_tx;
          t++;
          if (t == 10 * DIV) begin
            checkOutput("frameData", {24'b0, data}, {24'b0, expByte});
            checkOutput("frameShape", shapeErr, 32'd0);
            framesSeen++;
            inFrame = 1'b0;
          end
        end
        prevTx = o_tx;
      end
    end
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          lows;
    int          readys;
    int          f0;

    i_reset   = 1'b1;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_address = '0;
    i_wdata   = '0;
    repeat (3) @(negedge i_clock);
    checkOutput("resetTx", {31'b0, o_tx}, 32'd1);
    checkOutput("resetReady", {31'b0, o_ready}, 32'd0);
    checkOutput("resetRdata", o_rdata, 32'd0);
    checkOutput("resetIrq", {31'b0, o_interrupt}, 32'd0);
    i_reset = 1'b0;

    lows = 0;
    readys = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clock);
      if (o_tx !== 1'b1) lows++;
      if (o_ready !== 1'b0) readys++;
    end
    checkOutput("idleTxLow", lows, 32'd0);
    checkOutput("idleReady", readys, 32'd0);
    applyStimulus(1'b0, 2'd1, 32'd0, rd, lat);
    checkOutput("statusIdle", rd, 32'h2);
    checkOutput("readLatency", lat, 32'd2);

    $display("[TB] single byte 0x55");
    applyStimulus(1'b1, 2'd0, 32'h55, rd, lat);
    checkOutput("writeLatency", lat, 32'd2);
    repeat (20) @(negedge i_clock);
    checkOutput("startLatency", lastStartCyc - readyCyc, 32'd1);
    applyStimulus(1'b0, 2'd1, 32'd0, rd, lat);
    checkOutput("statusBusy", rd, 32'h6);
    repeat (100) @(negedge i_clock);
    checkOutput("frames55", framesSeen, 32'd1);
    applyStimulus(1'b0, 2'd1, 32'd0, rd, lat);
    checkOutput("statusAfter55", rd, 32'h2);

    $display("[TB] burst 0x01..0x06");
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 2'd0, i, rd, lat);
      checkOutput("burstAck", lat, 32'd2);
    end
    applyStimulus(1'b0, 2'd1, 32'd0, rd, lat);
    checkOutput("statusFull", rd, 32'h5);
    applyStimulus(1'b1, 2'd0, 32'h06, rd, lat);
    checkOutput("stallAck", {31'b0, (lat > 20)}, 32'd1);
    repeat (520) @(negedge i_clock);
    checkOutput("burstFrames", starts.size(), 32'd6);
    for (int i = 1; i < starts.size(); i++)
      checkOutput("frameGap", starts[i] - starts[i-1], 10 * DIV);
    checkOutput("burstQueue", expQ.size(), 32'd0);
    applyStimulus(1'b0, 2'd1, 32'd0, rd, lat);
    checkOutput("statusAfterBurst", rd, 32'h2);

    $display("[TB] reset during bit 3 of 0xA5");
    applyStimulus(1'b1, 2'd0, 32'hA5, rd, lat);
    applyStimulus(1'b1, 2'd0, 32'h3C, rd, lat);
    repeat (44) @(negedge i_clock);
    checkOutput("bit3Low", {31'b0, o_tx}, 32'd0);
    i_reset = 1'b1;
    @(negedge i_clock);
    checkOutput("abortTx", {31'b0, o_tx}, 32'd1);
    checkOutput("abortReady", {31'b0, o_ready}, 32'd0);
    i_reset = 1'b0;
    expQ.delete();
    f0 = framesSeen;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clock);
      if (o_tx !== 1'b1) lows++;
    end
    checkOutput("postResetLow", lows, 32'd0);
    checkOutput("postResetFrames", framesSeen - f0, 32'd0);
    applyStimulus(1'b0, 2'd1, 32'd0, rd, lat);
    checkOutput("statusAfterReset", rd, 32'h2);

    $display("[TB] interrupt");
`ifdef UART_TX_IRQ_EN
    applyStimulus(1'b1, 2'd2, 32'd1, rd, lat);
    checkOutput("irqEnabledIdle", {31'b0, o_interrupt}, 32'd1);
    applyStimulus(1'b0, 2'd2, 32'd0, rd, lat);
    checkOutput("ctrlRead", rd, 32'd1);
    applyStimulus(1'b1, 2'd0, 32'hFF, rd, lat);
    checkOutput("irqDropped", {31'b0, o_interrupt}, 32'd0);
    repeat (99) @(negedge i_clock);
    checkOutput("irqStop", {31'b0, o_interrupt}, 32'd0);
    @(negedge i_clock);
    checkOutput("irqLatency", {31'b0, o_interrupt}, 32'd0);
    @(negedge i_clock);
    checkOutput("irqBack", {31'b0, o_interrupt}, 32'd1);
`else
    applyStimulus(1'b1, 2'd2, 32'd1, rd, lat);
    checkOutput("irqTied", {31'b0, o_interrupt}, 32'd0);
    applyStimulus(1'b0, 2'd2, 32'd0, rd, lat);
    checkOutput("ctrlRead", rd, 32'd0);
    applyStimulus(1'b1, 2'd0, 32'hFF, rd, lat);
    repeat (110) @(negedge i_clock);
    checkOutput("irqTiedAfter", {31'b0, o_interrupt}, 32'd0);
`endif
    repeat (5) @(negedge i_clock);
    checkOutput("finalQueue", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
